// File: rtl/ccu_req_arbiter.sv
// Round-robin arbiter that shares the CCU snoop sequencer between ACE masters.
// It latches one winner, issues it, and holds the grant until the sequencer reports done.
module ccu_req_arbiter #(
    parameter int unsigned NoMstPorts = 4,
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned IdxWidth   = $clog2(NoMstPorts)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NoMstPorts-1:0]                req_valid_i,
    output logic [NoMstPorts-1:0]                req_ready_o,
    input  logic [NoMstPorts-1:0]                req_write_i,
    input  logic [NoMstPorts-1:0][AddrWidth-1:0] req_addr_i,
    input  logic [NoMstPorts-1:0][3:0]           req_snoop_i,
    output logic                                 ccu_valid_o,
    input  logic                                 ccu_ready_i,
    output logic                                 ccu_write_o,
    output logic [AddrWidth-1:0]                 ccu_addr_o,
    output logic [3:0]                           ccu_snoop_o,
    output logic [IdxWidth-1:0]                  ccu_src_o,
    output logic [NoMstPorts-1:0]                ccu_snoop_mask_o,
    input  logic                                 ccu_done_i,
    output logic                                 busy_o,
    output logic                                 spurious_done_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY
    } state_e;

    state_e                  state_q, state_d;
    logic [IdxWidth-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdxWidth-1:0]     winner;
    logic                    found;
    logic                    grant;
    int unsigned             scan_idx;
    logic [IdxWidth-1:0]     scan_idx_w;
    logic                    write_q;
    logic [AddrWidth-1:0]    addr_q;
    logic [3:0]              snoop_q;
    logic [IdxWidth-1:0]     src_q;
    logic                    spurious_q;
    logic [NoMstPorts-1:0]   src_onehot;

    // Scan from the pointer upwards, wrapping, and take the first valid master.
    always_comb begin
        winner     = '0;
        found      = 1'b0;
        scan_idx   = 0;
        scan_idx_w = '0;
        for (int unsigned i = 0; i < NoMstPorts; i++) begin
            scan_idx = 32'(rr_ptr_q) + i;
            if (scan_idx >= NoMstPorts) begin
                scan_idx = scan_idx - NoMstPorts;
            end
            scan_idx_w = IdxWidth'(scan_idx);
            if (!found && req_valid_i[scan_idx_w]) begin
                found  = 1'b1;
                winner = scan_idx_w;
            end
        end
    end

    assign grant = found && (state_q == IDLE);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            if (32'(winner) == NoMstPorts - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = winner + IdxWidth'(1);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (grant && rst_ni) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ccu_valid_o = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ccu_valid_o = 1'b1;
                busy_o      = 1'b1;
                if (ccu_ready_i) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy_o = 1'b1;
                if (ccu_done_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            snoop_q    <= '0;
            src_q      <= '0;
            spurious_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            spurious_q <= ccu_done_i && (state_q != BUSY);
            if (grant) begin
                write_q <= req_write_i[winner];
                addr_q  <= req_addr_i[winner];
                snoop_q <= req_snoop_i[winner];
                src_q   <= winner;
            end
        end
    end

    // Every master except the initiator gets snooped.
    always_comb begin
        src_onehot        = '0;
        src_onehot[src_q] = 1'b1;
        ccu_snoop_mask_o  = ~src_onehot;
    end

    assign ccu_write_o     = write_q;
    assign ccu_addr_o      = addr_q;
    assign ccu_snoop_o     = snoop_q;
    assign ccu_src_o       = src_q;
    assign spurious_done_o = spurious_q;

endmodule
